// File: rtl/elastic_merge_arbiter_pkg.sv
// Shared parameters and helpers for the elastic merge arbiter.
// Optional feature macro: ELASTIC_MERGE_ROUND_ROBIN_EN (round-robin pointer; default is fixed priority).
package elastic_merge_arbiter_pkg;

    localparam int EMA_DATA_WIDTH       = 32;
    localparam int EMA_NEIGHBOR_PE_NUM  = 4;

    // Increment a channel index with wrap at n (n need not be a power of two).
    function automatic int wrap_inc(int i, int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/elastic_merge_arbiter_rr_grant.sv
// Combinational grant: first requester scanning from ptr_i upward with wrap.
// With ptr_i tied to zero this degenerates to lowest-index fixed priority.
module elastic_rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/elastic_merge_arbiter.sv
// N-to-1 elastic merge with a single registered output stage.
// Define ELASTIC_MERGE_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module elastic_merge_arbiter
    import elastic_merge_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH      = EMA_DATA_WIDTH,
    parameter  int NEIGHBOR_PE_NUM = EMA_NEIGHBOR_PE_NUM,
    localparam int IDX_WIDTH       = $clog2(NEIGHBOR_PE_NUM)
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [NEIGHBOR_PE_NUM-1:0][DATA_WIDTH-1:0] input_data,
    input  logic [NEIGHBOR_PE_NUM-1:0]                 valid_input,
    output logic [NEIGHBOR_PE_NUM-1:0]                 stop_input,
    input  logic [NEIGHBOR_PE_NUM-1:0]                 available_input,
    output logic [DATA_WIDTH-1:0]                      output_data,
    output logic                                       valid_output,
    input  logic                                       stop_output,
    output logic [IDX_WIDTH-1:0]                       output_src
);

    logic [NEIGHBOR_PE_NUM-1:0] req;
    logic [NEIGHBOR_PE_NUM-1:0] gnt;
    logic [IDX_WIDTH-1:0]       gnt_idx;
    logic                       gnt_any;
    logic                       accept;
    logic [IDX_WIDTH-1:0]       ptr;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [IDX_WIDTH-1:0]  src_q,   src_d;

    assign req    = valid_input & available_input;
    assign accept = !valid_q || !stop_output;

    elastic_rr_grant #(
        .N     (NEIGHBOR_PE_NUM),
        .IDX_W (IDX_WIDTH)
    ) u_grant (
        .req_i (req),
        .ptr_i (ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Only the granted channel sees stop low, and never while in reset.
    assign stop_input = (reset_n && accept) ? ~gnt : '1;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (accept) begin
            valid_d = gnt_any;
            if (gnt_any) begin
                data_d = input_data[gnt_idx];
                src_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

`ifdef ELASTIC_MERGE_ROUND_ROBIN_EN
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    // Pointer moves past the winner only on an actual transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && gnt_any)
            ptr_d = IDX_WIDTH'(wrap_inc(int'(gnt_idx), NEIGHBOR_PE_NUM));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign output_data  = data_q;
    assign valid_output = valid_q;
    assign output_src   = src_q;

endmodule

// File: tb/tb_elastic_merge_arbiter.sv
// Directed + random bench for elastic_merge_arbiter against a cycle-level reference model.
module tb_elastic_merge_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic                 clk;
    logic                 reset_n;
    logic [N-1:0][DW-1:0] input_data;
    logic [N-1:0]         valid_input;
    logic [N-1:0]         stop_input;
    logic [N-1:0]         available_input;
    logic [DW-1:0]        output_data;
    logic                 valid_output;
    logic                 stop_output;
    logic [1:0]           output_src;

    int pass_cnt = 0;
    int total    = 0;

    // Reference state: what the output register should hold, and the priority pointer.
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_ptr;

    elastic_merge_arbiter #(.DATA_WIDTH(DW), .NEIGHBOR_PE_NUM(N)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .input_data      (input_data),
        .valid_input     (valid_input),
        .stop_input      (stop_input),
        .available_input (available_input),
        .output_data     (output_data),
        .valid_output    (valid_output),
        .stop_output     (stop_output),
        .output_src      (output_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    // One clock: check stop_input before the edge, outputs just after it.
    task automatic step();
        int         g;
        logic       acc;
        logic [N-1:0] es;
        #1;
        acc = !m_valid || !stop_output;
        g   = pick(valid_input & available_input, m_ptr);
        es  = '1;
        if (acc && g >= 0) es[g] = 1'b0;
        chk("stop_input", 32'(stop_input), 32'(es));
        @(posedge clk);
        if (acc) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = input_data[g];
                m_src   = g;
`ifdef ELASTIC_MERGE_ROUND_ROBIN_EN
                m_ptr   = (g + 1) % N;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("valid_output", 32'(valid_output), 32'(m_valid));
        chk("output_data",  output_data,       m_data);
        chk("output_src",   32'(output_src),   32'(m_src));
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        valid_input = '0;
        stop_output = 1'b0;
        model_reset();
        #2;
        chk("rst_stop_input",   32'(stop_input),   32'hF);
        chk("rst_valid_output", 32'(valid_output), 32'h0);
        chk("rst_output_data",  output_data,       32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] hold;
        int            seq [5];

        input_data      = '0;
        valid_input     = '0;
        available_input = '1;
        stop_output     = 1'b0;
        reset_n         = 1'b1;
        model_reset();
        #3;
        do_reset();

        // Single token on channel 2.
        input_data[2] = 32'hA5;
        valid_input   = 4'b0100;
        step();
        chk("single_data",  output_data,      32'hA5);
        chk("single_src",   32'(output_src),  32'd2);
        chk("single_valid", 32'(valid_output), 32'd1);
        valid_input = '0;
        step();

        // All channels valid continuously.
        do_reset();
        for (int i = 0; i < N; i++) input_data[i] = 32'h100 + 32'(i);
        valid_input = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            seq[i] = int'(output_src);
        end
        for (int i = 0; i < 5; i++) begin
`ifdef ELASTIC_MERGE_ROUND_ROBIN_EN
            chk("fair_src", 32'(seq[i]), 32'(i % N));
`else
            chk("fixed_all_src", 32'(seq[i]), 32'd0);
`endif
        end

        // Channels 1 and 3 contend.
        valid_input = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
`ifndef ELASTIC_MERGE_ROUND_ROBIN_EN
            chk("fixed_src", 32'(output_src), 32'd1);
`endif
        end

        // Backpressure for three cycles, then release with refill.
        valid_input = 4'hF;
        step();
        hold = output_data;
        stop_output = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_data[i] = 32'h200 + 32'(i);
            step();
            chk("bp_hold_data", output_data, hold);
            chk("bp_stop_all",  32'(stop_input), 32'hF);
        end
        stop_output = 1'b0;
        step();
        chk("bp_no_bubble", 32'(valid_output), 32'd1);
        valid_input = '0;
        step();

        // Masked requesters are never granted.
        valid_input     = 4'b1010;
        available_input = 4'b0101;
        step();
        chk("mask_stop13",  32'({stop_input[3], stop_input[1]}), 32'b11);
        step();
        chk("mask_valid",   32'(valid_output), 32'd0);
        available_input = '1;

        // Asynchronous reset while output is full and stalled.
        valid_input = 4'hF;
        step();
        stop_output = 1'b1;
        step();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 32'(valid_output), 32'd0);
        chk("async_data",  output_data,       32'd0);
        chk("async_stop",  32'(stop_input),   32'hF);
        @(posedge clk);
        #3 reset_n = 1'b1;
        stop_output = 1'b0;
        step();
        chk("post_reset_src", 32'(output_src), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) input_data[c] = $urandom;
            valid_input     = 4'($urandom);
            available_input = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            stop_output     = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
